// File: rtl/shader_input_arbiter_pkg.sv
// Shared types and constants for the shader input arbiter.
// The default channel count, payload width and FIFO depth live here.
package shader_input_arbiter_pkg;

  localparam int unsigned SHADER_NUM_CH = 5;
  localparam int unsigned SHADER_WIDTH  = 128;
  localparam int unsigned SHADER_DEPTH  = 4;

  // An occupancy field must be able to hold the value DEPTH itself.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned SHADER_OCC_W = occ_width(SHADER_DEPTH);

  typedef logic [SHADER_WIDTH-1:0]           shader_req_t;
  typedef logic [$clog2(SHADER_NUM_CH)-1:0]  chan_id_t;

endpackage

// File: rtl/shader_input_arbiter_if.sv
// Merged request bus. The pipeline side drives the requests and the shader stall;
// the arbiter drives the back-pressure, the merged output and the occupancy.
interface shader_input_arbiter_if
  import shader_input_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH = SHADER_NUM_CH,
  parameter int unsigned WIDTH  = SHADER_WIDTH,
  parameter int unsigned DEPTH  = SHADER_DEPTH
);
  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned OCC_W = occ_width(DEPTH);

  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_stall;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [CH_W-1:0]         out_ch;
  logic                    out_stall;
  logic [NUM_CH*OCC_W-1:0] occ;

  modport master (
    output in_valid, in_data, out_stall,
    input  in_stall, out_valid, out_data, out_ch, occ
  );

  modport slave (
    input  in_valid, in_data, out_stall,
    output in_stall, out_valid, out_data, out_ch, occ
  );

endinterface

// File: rtl/shader_chan_fifo.sv
// Per-channel first-word-fall-through FIFO; rd_data always shows the head entry.
// Pointers wrap naturally because DEPTH is a power of two.
module shader_chan_fifo
  import shader_input_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = SHADER_WIDTH,
  parameter int unsigned DEPTH = SHADER_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_wr;
  logic             w_rd;

  assign full    = (r_count == FULL_CNT);
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];
  assign w_wr    = wr_en && !full;
  assign w_rd    = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/shader_input_arbiter.sv
// N-channel shader front end: per-channel FIFOs drained by a round-robin or
// fixed-priority arbiter into one registered output tagged with its source channel.
module shader_input_arbiter
  import shader_input_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH = SHADER_NUM_CH,
  parameter int unsigned WIDTH  = SHADER_WIDTH,
  parameter int unsigned DEPTH  = SHADER_DEPTH,
  parameter int unsigned RR_EN  = 1
) (
  input logic                   clk,
  input logic                   rst,
  shader_input_arbiter_if.slave bus
);
  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned OCC_W = occ_width(DEPTH);

  logic [WIDTH-1:0]  w_rd_data [NUM_CH];
  logic [OCC_W-1:0]  w_count   [NUM_CH];
  logic              w_full    [NUM_CH];
  logic              w_empty   [NUM_CH];
  logic [NUM_CH-1:0] w_pop;
  logic [CH_W-1:0]   w_grant;
  logic [CH_W-1:0]   w_idx;
  logic              w_found;
  logic              w_load;

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [CH_W-1:0]   r_out_ch;
  logic [CH_W-1:0]   r_last_grant;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    shader_chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bus.in_valid[gi]),
      .wr_data (bus.in_data[gi*WIDTH +: WIDTH]),
      .rd_en   (w_pop[gi]),
      .rd_data (w_rd_data[gi]),
      .full    (w_full[gi]),
      .empty   (w_empty[gi]),
      .count   (w_count[gi])
    );
  end

  // Round-robin starts searching just after the last winner; fixed priority from 0.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (RR_EN != 0) w_idx = CH_W'((32'(r_last_grant) + 32'd1 + k) % NUM_CH);
      else            w_idx = CH_W'(k);
      if (!w_found && !w_empty[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  always_comb begin
    w_load = w_found && (!r_out_valid || !bus.out_stall);
    w_pop  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_pop[i] = w_load && (w_grant == CH_W'(i));
    end
  end

  always_comb begin
    bus.in_stall = '0;
    bus.occ      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      bus.in_stall[i]              = w_full[i];
      bus.occ[i*OCC_W +: OCC_W]    = w_count[i];
    end
  end

  // A stalled, valid output holds everything, including the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_ch     <= '0;
      r_last_grant <= CH_W'(NUM_CH - 1);
    end else if (!r_out_valid || !bus.out_stall) begin
      r_out_valid <= w_found;
      if (w_found) begin
        r_out_data   <= w_rd_data[w_grant];
        r_out_ch     <= w_grant;
        r_last_grant <= w_grant;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;

endmodule
